// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with write-back select, forwarding pair and late-load wait/timeout handling.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter output (retire_cnt).
module wb_stage_reg #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int ZERO_REG     = 31
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [63:0] ALUout_in,
    input  logic [63:0] MemData_in,
    input  logic        MemData_valid,
    input  logic [4:0]  Rd_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    output logic [63:0] RegDataIn,
    output logic [4:0]  Rd_write,
    output logic        RegWrite,
    output logic [4:0]  MemRegIn,
    output logic [63:0] MemValueIn,
    output logic        stall,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0] retire_cnt,
`endif
    output logic        err_timeout
);

    localparam int          CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [4:0]  ZR    = 5'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 2);

    typedef enum logic {RUN, WAIT_LOAD} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        rd_sv_q;
    logic              we_sv_q;
    logic [63:0]       data_q;
    logic [4:0]        rd_write_q;
    logic              regwrite_q;
    logic [4:0]        memreg_q;
    logic              err_q;
    logic              wr_en_d;
    logic              load_late;

    // MemRead_in carries no extra meaning here: MemToReg_in alone selects the load path.
    logic unused_memread;
    assign unused_memread = MemRead_in;

    assign wr_en_d   = RegWrite_in && (Rd_in != ZR);
    assign load_late = MemToReg_in && !MemData_valid;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;
    assign retire_cnt = retire_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            rd_sv_q    <= '0;
            we_sv_q    <= 1'b0;
            data_q     <= '0;
            rd_write_q <= '0;
            regwrite_q <= 1'b0;
            memreg_q   <= ZR;
            err_q      <= 1'b0;
`ifdef WB_RETIRE_CNT_EN
            retire_q   <= '0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    regwrite_q <= 1'b0;
                    memreg_q   <= ZR;
                    if (valid_in) begin
                        if (!load_late) begin
                            data_q     <= MemToReg_in ? MemData_in : ALUout_in;
                            rd_write_q <= Rd_in;
                            regwrite_q <= wr_en_d;
                            memreg_q   <= wr_en_d ? Rd_in : ZR;
`ifdef WB_RETIRE_CNT_EN
                            retire_q   <= retire_q + 64'd1;
`endif
                        end else begin
                            state_q <= WAIT_LOAD;
                            rd_sv_q <= Rd_in;
                            we_sv_q <= wr_en_d;
                            cnt_q   <= '0;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // Data arriving on the timeout edge still wins.
                    if (MemData_valid) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        data_q     <= MemData_in;
                        rd_write_q <= rd_sv_q;
                        regwrite_q <= we_sv_q;
                        memreg_q   <= we_sv_q ? rd_sv_q : ZR;
`ifdef WB_RETIRE_CNT_EN
                        retire_q   <= retire_q + 64'd1;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        // Incremented count would reach LOAD_TIMEOUT-1: abandon the load.
                        state_q <= RUN;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign stall       = (state_q == WAIT_LOAD);
    assign RegDataIn   = data_q;
    assign MemValueIn  = data_q;
    assign Rd_write    = rd_write_q;
    assign RegWrite    = regwrite_q;
    assign MemRegIn    = memreg_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: expected writes queued at stimulus time, checked by a monitor on each RegWrite pulse.
module tb_wb_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [63:0] ALUout_in;
    logic [63:0] MemData_in;
    logic        MemData_valid;
    logic [4:0]  Rd_in;
    logic        RegWrite_in;
    logic        MemToReg_in;
    logic        MemRead_in;
    logic [63:0] RegDataIn;
    logic [4:0]  Rd_write;
    logic        RegWrite;
    logic [4:0]  MemRegIn;
    logic [63:0] MemValueIn;
    logic        stall;
    logic        err_timeout;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    wb_stage_reg dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in),
        .ALUout_in(ALUout_in), .MemData_in(MemData_in), .MemData_valid(MemData_valid),
        .Rd_in(Rd_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .MemRead_in(MemRead_in), .RegDataIn(RegDataIn), .Rd_write(Rd_write),
        .RegWrite(RegWrite), .MemRegIn(MemRegIn), .MemValueIn(MemValueIn),
        .stall(stall),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: actual rd=%0d data=0x%0h required no write", Rd_write, RegDataIn);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_rd", 64'(Rd_write), 64'(e.rd));
                chk("wr_data", RegDataIn, e.data);
                chk("fwd_reg", 64'(MemRegIn), 64'(e.rd));
                chk("fwd_val", MemValueIn, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 0; MemToReg_in = 0; RegWrite_in = 0; MemData_valid = 0; MemRead_in = 0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [63:0] v, input logic we);
        valid_in = 1; MemToReg_in = 0; MemRead_in = 0; RegWrite_in = we; Rd_in = rd; ALUout_in = v;
        if (we && rd != 5'd31) exp_q.push_back('{rd: rd, data: v});
        tick();
    endtask

    // Issue a load whose data is absent on the capture edge.
    task automatic load_start(input logic [4:0] rd);
        valid_in = 1; MemToReg_in = 1; MemRead_in = 1; RegWrite_in = 1; Rd_in = rd; MemData_valid = 0;
        tick();
        idle();
    endtask

    initial begin
        reset_n = 0; Rd_in = 0; ALUout_in = 0; MemData_in = 0;
        idle();
        tick(); tick();
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_data", RegDataIn, 64'd0);
        chk("rst_rdwrite", 64'(Rd_write), 64'd0);
        chk("rst_memreg", 64'(MemRegIn), 64'd31);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        reset_n = 1;

        // ALU write to r5
        alu(5'd5, 64'h1234, 1'b1);
        chk("alu_regwrite", 64'(RegWrite), 64'd1);
        chk("alu_stall", 64'(stall), 64'd0);
        // Zero register never written or forwarded
        alu(5'd31, 64'h5555, 1'b1);
        chk("zr_regwrite", 64'(RegWrite), 64'd0);
        chk("zr_memreg", 64'(MemRegIn), 64'd31);
        // Bubble
        idle(); tick();
        chk("bubble_regwrite", 64'(RegWrite), 64'd0);
        chk("bubble_memreg", 64'(MemRegIn), 64'd31);

        // Late load to r3: three cycles of stall, then one write
        load_start(5'd3);
        chk("late_stall0", 64'(stall), 64'd1);
        chk("late_rw0", 64'(RegWrite), 64'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("late_stall", 64'(stall), 64'd1);
            chk("late_rw", 64'(RegWrite), 64'd0);
        end
        MemData_valid = 1; MemData_in = 64'hDEAD;
        exp_q.push_back('{rd: 5'd3, data: 64'hDEAD});
        tick();
        idle();
        chk("late_regwrite", 64'(RegWrite), 64'd1);
        chk("late_stall_end", 64'(stall), 64'd0);
        tick();
        chk("late_one_pulse", 64'(RegWrite), 64'd0);

        // Data on the timeout edge wins: r4 written, no error
        load_start(5'd4);
        for (int i = 1; i < 15; i++) tick();
        chk("edge_stall", 64'(stall), 64'd1);
        MemData_valid = 1; MemData_in = 64'hBEEF;
        exp_q.push_back('{rd: 5'd4, data: 64'hBEEF});
        tick();
        idle();
        chk("edge_regwrite", 64'(RegWrite), 64'd1);
        chk("edge_err", 64'(err_timeout), 64'd0);

        // Timeout: valid held low for 16 cycles including the capture cycle
        load_start(5'd9);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_err_low", 64'(err_timeout), 64'd0);
        end
        chk("to_stall_pre", 64'(stall), 64'd1);
        tick();
        chk("to_err", 64'(err_timeout), 64'd1);
        chk("to_stall", 64'(stall), 64'd0);
        chk("to_regwrite", 64'(RegWrite), 64'd0);
        alu(5'd7, 64'h77, 1'b1);
        chk("to_alu_rw", 64'(RegWrite), 64'd1);
        chk("to_err_sticky", 64'(err_timeout), 64'd1);
        idle(); tick();

        // Reset while waiting drops the pending write
        load_start(5'd6);
        chk("rw_stall", 64'(stall), 64'd1);
        reset_n = 0;
        tick();
        chk("rw_stall_rst", 64'(stall), 64'd0);
        chk("rw_rw_rst", 64'(RegWrite), 64'd0);
        chk("rw_err_rst", 64'(err_timeout), 64'd0);
        chk("rw_memreg_rst", 64'(MemRegIn), 64'd31);
        reset_n = 1;
        MemData_valid = 1; MemData_in = 64'h6666;
        tick();
        chk("rw_no_write", 64'(RegWrite), 64'd0);
        idle();

`ifdef WB_RETIRE_CNT_EN
        reset_n = 0; tick(); reset_n = 1;
        chk("rc_reset", retire_cnt, 64'd0);
        alu(5'd10, 64'hA, 1'b1);
        alu(5'd11, 64'hB, 1'b1);
        alu(5'd12, 64'hC, 1'b0);
        alu(5'd13, 64'hD, 1'b1);
        idle(); tick();
        chk("rc_four", retire_cnt, 64'd4);
        load_start(5'd14);
        tick();
        MemData_valid = 1; MemData_in = 64'hE;
        exp_q.push_back('{rd: 5'd14, data: 64'hE});
        tick();
        idle();
        chk("rc_five", retire_cnt, 64'd5);
`endif

        tick(); tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
- MEM/WB pipeline register and write-back control for the 5-stage CPU.
- Takes the ALU result, load data and control bits from the memory stage. Selects the write-back value and drives the register-file write port (RegDataIn, Rd_write, RegWrite) consumed by the register-fetch stage.
- Also sources the MemRegIn/MemValueIn forwarding pair for the fetch stage.
- Handles loads whose read data arrives late: waits for a data-valid handshake and stalls upstream meanwhile.

Parameters:
- LOAD_TIMEOUT, 16: max cycles in WAIT_LOAD before the load is abandoned and err_timeout is set.
- ZERO_REG, 31: register index hard-wired to zero; never written, never forwarded.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset_n  input  1  synchronous, active-low reset
- valid_in  input  1  memory-stage slot holds a real instruction
- ALUout_in  input  64  ALU result from memory stage
- MemData_in  input  64  load data from data memory
- MemData_valid  input  1  MemData_in valid this cycle
- Rd_in  input  5  destination register
- RegWrite_in  input  1  instruction writes Rd
- MemToReg_in  input  1  1 = write-back load data, 0 = ALU result
- MemRead_in  input  1  instruction is a load
- RegDataIn  output  64  register-file write data
- Rd_write  output  5  register-file write index
- RegWrite  output  1  register-file write enable
- MemRegIn  output  5  forwarding register index to fetch stage
- MemValueIn  output  64  forwarding value to fetch stage
- stall  output  1  hold memory stage and everything upstream
- err_timeout  output  1  sticky: a load exceeded LOAD_TIMEOUT

Behaviour:
- Reset (reset_n=0 at rising edge) clears all outputs to 0 and MemRegIn to ZERO_REG. State goes to RUN, timeout counter to 0, err_timeout to 0. Reset mid-WAIT_LOAD drops the pending write.
- States are RUN and WAIT_LOAD.
- RUN, capture at rising edge with valid_in=1:
  - Latch Rd_in, RegWrite_in and MemToReg_in.
  - Write enable = RegWrite_in && Rd_in!=ZERO_REG.
  - If MemToReg_in=0: RegDataIn=ALUout_in. Outputs are valid the cycle after capture (1-cycle latency).
  - If MemToReg_in=1 and MemData_valid=1: RegDataIn=MemData_in, same 1-cycle latency.
  - If MemToReg_in=1 and MemData_valid=0: go to WAIT_LOAD. RegWrite=0 for that cycle.
- RUN with valid_in=0: RegWrite=0 next cycle. MemRegIn=ZERO_REG.
- WAIT_LOAD:
  - stall=1, combinationally decoded from state. valid_in and new inputs are ignored; upstream holds them.
  - On an edge with MemData_valid=1: latch MemData_in and return to RUN. RegWrite is asserted for exactly one cycle after, with the saved Rd. Counter clears.
  - Counter increments each WAIT_LOAD cycle. When it reaches LOAD_TIMEOUT-1 without valid: set err_timeout, return to RUN, and suppress the write (RegWrite=0).
  - MemData_valid on the same edge as the timeout: data wins, write happens, no error.
- stall=0 in RUN. Stall is never asserted for ALU results.
- Forwarding:
  - MemRegIn = Rd_write when RegWrite=1, else ZERO_REG.
  - MemValueIn = RegDataIn. Both outputs are registered and identical in timing to the write port.
- RegWrite is never 1 for Rd=ZERO_REG, including after WAIT_LOAD.
- err_timeout clears only on reset.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined, adds output retire_cnt [63:0]. It counts instructions retired through write-back: each capture with valid_in=1 that completes (RUN pass-through, or WAIT_LOAD ending in valid data). This includes RegWrite_in=0 instructions (stores, branches). Timed-out loads are not counted. It resets to 0 and wraps modulo 2^64.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU write: valid_in=1, MemToReg_in=0, RegWrite_in=1, Rd_in=5, ALUout_in=0x1234. Next cycle: RegWrite=1, Rd_write=5, RegDataIn=0x1234, MemRegIn=5, MemValueIn=0x1234, stall=0.
- Zero register: same stimulus with Rd_in=31. Next cycle: RegWrite=0, MemRegIn=31.
- Late load: MemToReg_in=1, Rd_in=3, MemData_valid=0 for 3 cycles, then valid with MemData_in=0xDEAD.
  - stall=1 for exactly 3 cycles, RegWrite=0 throughout.
  - One cycle after valid: RegWrite=1, Rd_write=3, RegDataIn=0xDEAD. stall back to 0.
- Timeout: load with MemData_valid held 0 for LOAD_TIMEOUT cycles. err_timeout=1, state back to RUN, no RegWrite pulse. A subsequent ALU write to Rd=7 completes normally.
- Reset mid-wait: reset_n=0 during WAIT_LOAD. Next cycle: stall=0, RegWrite=0, err_timeout=0, MemRegIn=31. Late MemData_valid after reset causes no write.
- With WB_RETIRE_CNT_EN: 4 ALU instructions, 1 bubble, 1 late load. retire_cnt=5 after the load's write cycle.
